// File: rtl/iter_divider_if.sv
// Request/result bundle between the multdiv control and the iterative divider.
// The master drives the operands and start; the slave returns the results and status.
interface iter_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             result_ready;
    logic             exception;
    logic             busy;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, result_ready, exception, busy
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, result_ready, exception, busy
    );
endinterface

// File: rtl/iter_divider.sv
// Purpose: signed divider; runs one non-restoring step per clock on operand magnitudes, then fixes the signs.
// Latency: result_ready is high 34 cycles after the start cycle, or 1 cycle after it for a zero divisor.
// Backpressure: none; start is sampled only when idle, and requests made while busy are dropped.
module iter_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clock,
    input  logic          reset,
    iter_divider_if.slave dif
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] qmag;
    logic [WIDTH-1:0] dmag;
    logic             sign_q;
    logic             sign_r;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             exception_q;

    logic [WIDTH-1:0] abs_dividend;
    logic [WIDTH-1:0] abs_divisor;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   step_res;
    logic [WIDTH-1:0] fix_rem;

    // The magnitude of the most negative value wraps to itself and is read as unsigned.
    assign abs_dividend = dif.dividend[WIDTH-1] ? -dif.dividend : dif.dividend;
    assign abs_divisor  = dif.divisor[WIDTH-1]  ? -dif.divisor  : dif.divisor;

    // The partial remainder stays within [-dmag, dmag), so its top two bits always agree
    // and dropping bit WIDTH when shifting loses nothing.
    assign shifted  = {prem[WIDTH-1:0], qmag[WIDTH-1]};
    assign step_res = prem[WIDTH] ? shifted + {1'b0, dmag} : shifted - {1'b0, dmag};
    assign fix_rem  = prem[WIDTH] ? prem[WIDTH-1:0] + dmag : prem[WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            prem        <= '0;
            qmag        <= '0;
            dmag        <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            exception_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dif.start) begin
                        qmag   <= abs_dividend;
                        dmag   <= abs_divisor;
                        sign_q <= dif.dividend[WIDTH-1] ^ dif.divisor[WIDTH-1];
                        sign_r <= dif.dividend[WIDTH-1];
                        prem   <= '0;
                        cnt    <= '0;
                        if (dif.divisor == '0) begin
                            quotient_q  <= '0;
                            remainder_q <= '0;
                            exception_q <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    prem <= step_res;
                    qmag <= {qmag[WIDTH-2:0], ~step_res[WIDTH]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    quotient_q  <= sign_q ? -qmag : qmag;
                    remainder_q <= sign_r ? -fix_rem : fix_rem;
                    exception_q <= 1'b0;
                    state       <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dif.quotient     = quotient_q;
    assign dif.remainder    = remainder_q;
    assign dif.exception    = exception_q;
    assign dif.result_ready = (state == ST_DONE);
    assign dif.busy         = (state != ST_IDLE);
endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Sequential signed 32-bit integer divider; the inverse-operation companion to the radix-4 Booth multiplier step in the multdiv unit.
- Accepts dividend/divisor on a start pulse and runs one non-restoring iteration per clock on magnitudes.
- Applies sign correction and returns quotient, remainder and a divide-by-zero flag with a one-cycle ready pulse.
- Sits beside the multiplier under the processor's multdiv control (ctrl_DIV drives start).

Parameters:
WIDTH, 32, operand/result width in bits (only 32 is verified)
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  32  signed two's-complement numerator
divisor  input  32  signed two's-complement denominator
quotient  output  32  signed result, truncated toward zero
remainder  output  32  signed remainder, sign follows dividend
result_ready  output  1  one-cycle pulse when quotient/remainder/exception are valid
exception  output  1  divide-by-zero flag, valid with result_ready
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE, quotient=0, remainder=0, result_ready=0, exception=0, busy=0, counter=0. Reset in any state aborts the operation next edge; no result_ready is produced for the aborted request.
- States: IDLE, RUN, FIX, DONE.
- IDLE: on edge with start=1, latch |dividend|, |divisor|, sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend); clear 33-bit partial remainder, counter=0.
  - If divisor==0 -> DONE, with quotient=0, remainder=0, exception=1.
  - Otherwise -> RUN.
- RUN: per edge, shift {partial remainder, quotient-magnitude} left by 1.
  - If partial remainder >= 0, subtract divisor magnitude; else add it.
  - New quotient LSB = NOT(sign of result). Counter increments.
  - After exactly WIDTH iterations (counter reaches WIDTH-1 on the last) -> FIX.
- FIX: if partial remainder < 0, add divisor magnitude once (restore).
  - Negate quotient magnitude if sign_q; negate remainder if sign_r.
  - Register into quotient/remainder, exception=0, -> DONE.
- DONE: result_ready=1 for this single cycle, -> IDLE unconditionally. start during DONE is ignored.
- Latency: start accepted at edge E. Normal result_ready is high in the cycle after edge E+33 (32 RUN + 1 FIX). Divide-by-zero result_ready is high in the cycle after edge E.
- start while busy (RUN/FIX/DONE) is ignored; in-flight operands are unaffected by input changes after the accepting edge.
- quotient, remainder and exception hold their last values until the next accepted start completes. They are not cleared on start.
- Magnitude of -2^31 is 0x80000000 treated as unsigned. The 33-bit partial remainder prevents overflow.
- -2^31 / -1 gives quotient 0x80000000 (wraps), remainder 0, exception 0.
- Dividend 0 with nonzero divisor gives quotient 0, remainder 0, full latency.
- busy=1 from the cycle after the accepting edge through the DONE cycle inclusive.

Test Plan:
- Reset, then start with 100 / 7 -> result_ready exactly 34 cycles after start cycle; quotient=14, remainder=2, exception=0; busy high 34 cycles.
- -100 / 7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); 100 / -7 -> quotient=-14, remainder=2; -100 / -7 -> quotient=14, remainder=-2.
- 7 / 0 -> result_ready in the next cycle after acceptance; exception=1, quotient=0, remainder=0. A following 9 / 3 gives exception=0, quotient=3, remainder=0.
- 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. 0x80000000 / 2 -> quotient=0xC0000000, remainder=0. 0x7FFFFFFF / 0x7FFFFFFF -> quotient=1, remainder=0.
- Start 1000/3; pulse start with 5/5 at cycle 10 -> second request ignored; result is quotient=333, remainder=1, with a single result_ready.
- Start 1000/3; assert reset at cycle 15 -> IDLE, all outputs 0, no result_ready. A new start with 50/8 after release gives quotient=6, remainder=2.
